rv_pipe_controller: RTL and testbench
=====================================

# rv_pipe_controller

Registered, parametrised successor to the team's combinational RV32I decoder. Decodes the instruction in the decode stage, presents a one-cycle-latched control bundle to execute/writeback, sequences multi-cycle M-extension ops through a start/done handshake with the MDU, inserts bubbles on taken-branch flush, and flags and counts illegal encodings.

## Interface
- ENABLE_M, 1: when 1, decode R-type with funct7=0000001 as MUL/DIV; when 0, those encodings are illegal.
- ALU_OP_W, 5: alu_op width; must be at least 5.
- CNT_W, 8: width of the saturating illegal-instruction counter.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  opcode/funct fields are valid this cycle.
- opcode  in  7  instr[6:0].
- funct3  in  3  instr[14:12].
- funct7  in  7  instr[31:25].
- br_taken  in  1  execute-stage taken branch/jump redirect; flushes decode.
- mdu_done  in  1  MDU result ready, one-cycle pulse.
- alu_op  out  ALU_OP_W  ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASS_B 10, undefined 31.
- reg_write  out  1  register-file write enable.
- PCen  out  1  PC/fetch advance enable; 0 = stall.
- read_en  out  1  data-memory read.
- write_en  out  1  data-memory write.
- wb_sel  out  2  00 mem, 01 ALU, 10 PC+4, 11 MDU.
- br_type  out  2  00 none, 01 conditional branch, 10 jump.
- sel_A  out  1  1 = rs1, 0 = PC.
- sel_B  out  1  1 = rs2, 0 = immediate.
- mdu_start  out  1  one-cycle MDU launch pulse.
- mdu_op  out  3  funct3 of the M op, held stable for the whole MDU operation.
- illegal  out  1  one-cycle pulse for an illegal decoded instruction.
- illegal_cnt  out  CNT_W  saturating count of illegal instructions.

## Operation
- **Decode (combinational, latched at the clock edge).**
  - R-type 0110011 (funct7 0000000/0100000): the ten base ALU ops; sel_A=1, sel_B=1, wb_sel=01, reg_write=1.
  - I-ALU 0010011: ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI; funct3 101 gives SRLI when funct7[5]=0, SRAI when 1. sel_B=0.
  - LOAD 0000011: funct3 in {000, 001, 010, 100, 101} → ADD, read_en=1, wb_sel=00, sel_A=1, sel_B=0. Any other funct3 is illegal.
  - STORE 0100011: funct3 in {000, 001, 010} → ADD, write_en=1, reg_write=0, sel_A=1, sel_B=0.
  - BRANCH 1100011: br_type=01, sel_A=0, sel_B=0, ADD, no writes.
  - JAL 1101111: br_type=10, wb_sel=10, sel_A=0, sel_B=0, ADD.
  - JALR 1100111: br_type=10, wb_sel=10, sel_A=1, sel_B=0, ADD.
  - LUI 0110111: PASS_B, sel_B=0, wb_sel=01.
  - AUIPC 0010111: ADD, sel_A=0, sel_B=0, wb_sel=01.
  - M-ops: see the MDU_WAIT state below.
  - Illegal (any other opcode/funct combination, or M-op with ENABLE_M=0): a bubble with alu_op=31 plus an illegal pulse.
- **Bubble:** reg_write=0, read_en=0, write_en=0, br_type=00, alu_op=0, wb_sel=01, sel_A=1, sel_B=1, mdu_start=0.
- **FSM states: RUN, MDU_WAIT.**
  - RUN: instr_valid=0 latches a bubble. br_taken=1 latches a bubble regardless of instr_valid, and suppresses illegal and mdu_start.
  - RUN + valid M-op with no flush: latch a bubble, mdu_start=1, mdu_op=funct3, PCen=0, then go to MDU_WAIT.
  - MDU_WAIT: outputs hold a bubble with PCen=0; instr_valid and br_taken are ignored. On mdu_done, next cycle drives reg_write=1, wb_sel=11, PCen=1, then returns to RUN.
- **illegal_cnt:** increments on every illegal pulse and saturates at 2^CNT_W−1. Flushed or invalid instructions never count.

## Timing
- Reset (asynchronous): state=RUN, all outputs 0 including PCen, illegal_cnt=0.
- PCen=1 from the first clock edge after rst_n deasserts, unless that edge launches an M-op.
- Decode latency is one cycle: fields sampled at edge N appear on outputs after edge N.
- mdu_start is high for exactly one cycle. mdu_done may arrive as early as the cycle after mdu_start. The writeback cycle follows the edge that samples mdu_done.
- PCen stays low from the mdu_start cycle through the cycle that samples mdu_done.
- br_taken and an M-op at the same edge: flush wins, no mdu_start, state stays RUN.
- rst_n asserted during MDU_WAIT: immediate return to RUN with a reset bundle. A mdu_done arriving after reset is ignored.

## Test plan
- **Reset:** hold rst_n=0, drive opcode 0110011 → all outputs 0. Release → next edge gives reg_write=1, alu_op=0, PCen=1.
- **Base decode sweep:** SUB, SRAI (funct7 0100000), LW, SW, BEQ, JALR, LUI → alu_op 1, 7, 0, 0, 0, 0, 10 with the listed sel/wb/br fields, one cycle after each input.
- **MUL handshake:** funct7=0000001, funct3=000, mdu_done 3 cycles after mdu_start → mdu_start for 1 cycle, mdu_op=000, PCen=0 for 4 cycles, then reg_write=1, wb_sel=11.
- **ENABLE_M=0, same MUL:** illegal=1 for one cycle, alu_op=31, no mdu_start, illegal_cnt increments by 1.
- **Flush:** br_taken=1 with a valid ADD → bubble (reg_write=0). br_taken=1 with an M-op → no mdu_start. br_taken=1 with an illegal opcode → illegal_cnt unchanged.
- **Saturation:** CNT_W=2, five illegal opcodes (e.g. 1111111) → illegal_cnt 1, 2, 3, 3, 3. Asserting rst_n=0 mid-MDU_WAIT → PCen=0, state RUN, illegal_cnt=0.

Source files
------------

// File: rtl/rv_pipe_controller.sv
// RV32I decode-stage controller: registered control bundle, MDU start/done sequencing,
// branch-flush bubbles and a saturating illegal-instruction counter.
module rv_pipe_controller #(
   parameter int ENABLE_M = 1,
   parameter int ALU_OP_W = 5,
   parameter int CNT_W    = 8
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_instr_valid,
   input  logic [6:0]          i_opcode,
   input  logic [2:0]          i_funct3,
   input  logic [6:0]          i_funct7,
   input  logic                i_br_taken,
   input  logic                i_mdu_done,
   output logic [ALU_OP_W-1:0] o_alu_op,
   output logic                o_reg_write,
   output logic                o_PCen,
   output logic                o_read_en,
   output logic                o_write_en,
   output logic [1:0]          o_wb_sel,
   output logic [1:0]          o_br_type,
   output logic                o_sel_A,
   output logic                o_sel_B,
   output logic                o_mdu_start,
   output logic [2:0]          o_mdu_op,
   output logic                o_illegal,
   output logic [CNT_W-1:0]    o_illegal_cnt
);

   typedef enum logic {ST_RUN, ST_MDU_WAIT} state_t;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [ALU_OP_W-1:0] ALU_ADD    = ALU_OP_W'(0);
   localparam logic [ALU_OP_W-1:0] ALU_SUB    = ALU_OP_W'(1);
   localparam logic [ALU_OP_W-1:0] ALU_SLL    = ALU_OP_W'(2);
   localparam logic [ALU_OP_W-1:0] ALU_SLT    = ALU_OP_W'(3);
   localparam logic [ALU_OP_W-1:0] ALU_SLTU   = ALU_OP_W'(4);
   localparam logic [ALU_OP_W-1:0] ALU_XOR    = ALU_OP_W'(5);
   localparam logic [ALU_OP_W-1:0] ALU_SRL    = ALU_OP_W'(6);
   localparam logic [ALU_OP_W-1:0] ALU_SRA    = ALU_OP_W'(7);
   localparam logic [ALU_OP_W-1:0] ALU_OR     = ALU_OP_W'(8);
   localparam logic [ALU_OP_W-1:0] ALU_AND    = ALU_OP_W'(9);
   localparam logic [ALU_OP_W-1:0] ALU_PASS_B = ALU_OP_W'(10);
   localparam logic [ALU_OP_W-1:0] ALU_UNDEF  = ALU_OP_W'(31);

   localparam logic [1:0] WB_MEM  = 2'b00;
   localparam logic [1:0] WB_ALU  = 2'b01;
   localparam logic [1:0] WB_PC4  = 2'b10;
   localparam logic [1:0] WB_MDU  = 2'b11;
   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_COND = 2'b01;
   localparam logic [1:0] BR_JUMP = 2'b10;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [ALU_OP_W-1:0] base_alu_op(input logic [2:0] f3, input logic alt);
      logic [ALU_OP_W-1:0] op;
      case (f3)
         3'b000:  op = ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   state_t              r_state;
   logic [ALU_OP_W-1:0] r_alu_op_p1;
   logic                r_reg_write_p1;
   logic                r_pcen_p1;
   logic                r_read_en_p1;
   logic                r_write_en_p1;
   logic [1:0]          r_wb_sel_p1;
   logic [1:0]          r_br_type_p1;
   logic                r_sel_a_p1;
   logic                r_sel_b_p1;
   logic                r_mdu_start_p1;
   logic [2:0]          r_mdu_op_p1;
   logic                r_illegal_p1;
   logic [CNT_W-1:0]    r_illegal_cnt_p1;

   logic [ALU_OP_W-1:0] w_dec_alu_op;
   logic                w_dec_reg_write;
   logic                w_dec_read_en;
   logic                w_dec_write_en;
   logic [1:0]          w_dec_wb_sel;
   logic [1:0]          w_dec_br_type;
   logic                w_dec_sel_a;
   logic                w_dec_sel_b;
   logic                w_dec_mop;
   logic                w_dec_illegal;
   logic                w_vld_p0;

   state_t              w_state_nxt;
   logic [ALU_OP_W-1:0] w_alu_op_nxt;
   logic                w_reg_write_nxt;
   logic                w_pcen_nxt;
   logic                w_read_en_nxt;
   logic                w_write_en_nxt;
   logic [1:0]          w_wb_sel_nxt;
   logic [1:0]          w_br_type_nxt;
   logic                w_sel_a_nxt;
   logic                w_sel_b_nxt;
   logic                w_mdu_start_nxt;
   logic [2:0]          w_mdu_op_nxt;
   logic                w_illegal_nxt;

   // Stage p0: decode of the raw fields; anything unrecognised falls through as illegal.
   always_comb begin
      w_dec_alu_op    = ALU_ADD;
      w_dec_reg_write = 1'b0;
      w_dec_read_en   = 1'b0;
      w_dec_write_en  = 1'b0;
      w_dec_wb_sel    = WB_ALU;
      w_dec_br_type   = BR_NONE;
      w_dec_sel_a     = 1'b1;
      w_dec_sel_b     = 1'b1;
      w_dec_mop       = 1'b0;
      w_dec_illegal   = 1'b0;
      case (i_opcode)
         OP_RTYPE: begin
            if (i_funct7 == F7_MULDIV) begin
               if (ENABLE_M != 0) w_dec_mop = 1'b1;
               else               w_dec_illegal = 1'b1;
            end else if (i_funct7 == F7_BASE) begin
               w_dec_reg_write = 1'b1;
               w_dec_alu_op    = base_alu_op(i_funct3, 1'b0);
            end else if (i_funct7 == F7_ALT && (i_funct3 == 3'b000 || i_funct3 == 3'b101)) begin
               w_dec_reg_write = 1'b1;
               w_dec_alu_op    = (i_funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
            end else begin
               w_dec_illegal = 1'b1;
            end
         end
         OP_IALU: begin
            w_dec_reg_write = 1'b1;
            w_dec_sel_b     = 1'b0;
            w_dec_alu_op    = base_alu_op(i_funct3, i_funct7[5]);
         end
         OP_LOAD: begin
            if (i_funct3 == 3'b011 || i_funct3 == 3'b110 || i_funct3 == 3'b111) begin
               w_dec_illegal = 1'b1;
            end else begin
               w_dec_reg_write = 1'b1;
               w_dec_read_en   = 1'b1;
               w_dec_wb_sel    = WB_MEM;
               w_dec_sel_b     = 1'b0;
            end
         end
         OP_STORE: begin
            if (i_funct3[2] || i_funct3 == 3'b011) begin
               w_dec_illegal = 1'b1;
            end else begin
               w_dec_write_en = 1'b1;
               w_dec_sel_b    = 1'b0;
            end
         end
         OP_BRANCH: begin
            w_dec_br_type = BR_COND;
            w_dec_sel_a   = 1'b0;
            w_dec_sel_b   = 1'b0;
         end
         OP_JAL: begin
            w_dec_reg_write = 1'b1;
            w_dec_br_type   = BR_JUMP;
            w_dec_wb_sel    = WB_PC4;
            w_dec_sel_a     = 1'b0;
            w_dec_sel_b     = 1'b0;
         end
         OP_JALR: begin
            w_dec_reg_write = 1'b1;
            w_dec_br_type   = BR_JUMP;
            w_dec_wb_sel    = WB_PC4;
            w_dec_sel_b     = 1'b0;
         end
         OP_LUI: begin
            w_dec_reg_write = 1'b1;
            w_dec_alu_op    = ALU_PASS_B;
            w_dec_sel_b     = 1'b0;
         end
         OP_AUIPC: begin
            w_dec_reg_write = 1'b1;
            w_dec_sel_a     = 1'b0;
            w_dec_sel_b     = 1'b0;
         end
         default: w_dec_illegal = 1'b1;
      endcase
      if (w_dec_illegal) w_dec_alu_op = ALU_UNDEF;
   end

   // A flushed instruction is treated exactly like an invalid one.
   assign w_vld_p0 = i_instr_valid && !i_br_taken;

   always_comb begin
      w_state_nxt     = r_state;
      w_alu_op_nxt    = ALU_ADD;
      w_reg_write_nxt = 1'b0;
      w_pcen_nxt      = 1'b1;
      w_read_en_nxt   = 1'b0;
      w_write_en_nxt  = 1'b0;
      w_wb_sel_nxt    = WB_ALU;
      w_br_type_nxt   = BR_NONE;
      w_sel_a_nxt     = 1'b1;
      w_sel_b_nxt     = 1'b1;
      w_mdu_start_nxt = 1'b0;
      w_mdu_op_nxt    = r_mdu_op_p1;
      w_illegal_nxt   = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (w_vld_p0) begin
               w_alu_op_nxt    = w_dec_alu_op;
               w_reg_write_nxt = w_dec_reg_write;
               w_read_en_nxt   = w_dec_read_en;
               w_write_en_nxt  = w_dec_write_en;
               w_wb_sel_nxt    = w_dec_wb_sel;
               w_br_type_nxt   = w_dec_br_type;
               w_sel_a_nxt     = w_dec_sel_a;
               w_sel_b_nxt     = w_dec_sel_b;
               w_illegal_nxt   = w_dec_illegal;
               if (w_dec_mop) begin
                  w_mdu_start_nxt = 1'b1;
                  w_mdu_op_nxt    = i_funct3;
                  w_pcen_nxt      = 1'b0;
                  w_state_nxt     = ST_MDU_WAIT;
               end
            end
         end
         ST_MDU_WAIT: begin
            w_pcen_nxt = 1'b0;
            if (i_mdu_done) begin
               w_reg_write_nxt = 1'b1;
               w_wb_sel_nxt    = WB_MDU;
               w_pcen_nxt      = 1'b1;
               w_state_nxt     = ST_RUN;
            end
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   // Stage p1: registered control bundle seen by execute/writeback.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state          <= ST_RUN;
         r_alu_op_p1      <= '0;
         r_reg_write_p1   <= 1'b0;
         r_pcen_p1        <= 1'b0;
         r_read_en_p1     <= 1'b0;
         r_write_en_p1    <= 1'b0;
         r_wb_sel_p1      <= 2'b00;
         r_br_type_p1     <= 2'b00;
         r_sel_a_p1       <= 1'b0;
         r_sel_b_p1       <= 1'b0;
         r_mdu_start_p1   <= 1'b0;
         r_mdu_op_p1      <= 3'b000;
         r_illegal_p1     <= 1'b0;
         r_illegal_cnt_p1 <= '0;
      end else begin
         r_state          <= w_state_nxt;
         r_alu_op_p1      <= w_alu_op_nxt;
         r_reg_write_p1   <= w_reg_write_nxt;
         r_pcen_p1        <= w_pcen_nxt;
         r_read_en_p1     <= w_read_en_nxt;
         r_write_en_p1    <= w_write_en_nxt;
         r_wb_sel_p1      <= w_wb_sel_nxt;
         r_br_type_p1     <= w_br_type_nxt;
         r_sel_a_p1       <= w_sel_a_nxt;
         r_sel_b_p1       <= w_sel_b_nxt;
         r_mdu_start_p1   <= w_mdu_start_nxt;
         r_mdu_op_p1      <= w_mdu_op_nxt;
         r_illegal_p1     <= w_illegal_nxt;
         if (w_illegal_nxt) r_illegal_cnt_p1 <= sat_inc(r_illegal_cnt_p1);
      end
   end

   assign o_alu_op      = r_alu_op_p1;
   assign o_reg_write   = r_reg_write_p1;
   assign o_PCen        = r_pcen_p1;
   assign o_read_en     = r_read_en_p1;
   assign o_write_en    = r_write_en_p1;
   assign o_wb_sel      = r_wb_sel_p1;
   assign o_br_type     = r_br_type_p1;
   assign o_sel_A       = r_sel_a_p1;
   assign o_sel_B       = r_sel_b_p1;
   assign o_mdu_start   = r_mdu_start_p1;
   assign o_mdu_op      = r_mdu_op_p1;
   assign o_illegal     = r_illegal_p1;
   assign o_illegal_cnt = r_illegal_cnt_p1;

endmodule

// File: tb/tb_rv_pipe_controller.sv
// Directed bench for rv_pipe_controller: one default instance (M enabled, 8-bit counter)
// and one with M disabled and a 2-bit counter, both driven from the same decode fields.
module tb_rv_pipe_controller;

   logic       clk = 1'b0;
   logic       rst_n, rst_n_b;
   logic       instr_valid, br_taken, mdu_done;
   logic [6:0] opcode, funct7;
   logic [2:0] funct3;

   logic [4:0] a_alu_op, b_alu_op;
   logic       a_reg_write, a_pcen, a_read_en, a_write_en, a_sel_a, a_sel_b, a_mdu_start, a_illegal;
   logic       b_reg_write, b_pcen, b_read_en, b_write_en, b_sel_a, b_sel_b, b_mdu_start, b_illegal;
   logic [1:0] a_wb_sel, a_br_type, b_wb_sel, b_br_type;
   logic [2:0] a_mdu_op, b_mdu_op;
   logic [7:0] a_cnt;
   logic [1:0] b_cnt;

   logic [16:0] a_vec, b_vec;
   assign a_vec = {a_alu_op, a_reg_write, a_pcen, a_read_en, a_write_en, a_wb_sel, a_br_type,
                   a_sel_a, a_sel_b, a_mdu_start, a_illegal};
   assign b_vec = {b_alu_op, b_reg_write, b_pcen, b_read_en, b_write_en, b_wb_sel, b_br_type,
                   b_sel_a, b_sel_b, b_mdu_start, b_illegal};

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   rv_pipe_controller dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_instr_valid(instr_valid), .i_opcode(opcode),
      .i_funct3(funct3), .i_funct7(funct7), .i_br_taken(br_taken), .i_mdu_done(mdu_done),
      .o_alu_op(a_alu_op), .o_reg_write(a_reg_write), .o_PCen(a_pcen), .o_read_en(a_read_en),
      .o_write_en(a_write_en), .o_wb_sel(a_wb_sel), .o_br_type(a_br_type), .o_sel_A(a_sel_a),
      .o_sel_B(a_sel_b), .o_mdu_start(a_mdu_start), .o_mdu_op(a_mdu_op), .o_illegal(a_illegal),
      .o_illegal_cnt(a_cnt)
   );

   rv_pipe_controller #(.ENABLE_M(0), .ALU_OP_W(5), .CNT_W(2)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n_b), .i_instr_valid(instr_valid), .i_opcode(opcode),
      .i_funct3(funct3), .i_funct7(funct7), .i_br_taken(br_taken), .i_mdu_done(mdu_done),
      .o_alu_op(b_alu_op), .o_reg_write(b_reg_write), .o_PCen(b_pcen), .o_read_en(b_read_en),
      .o_write_en(b_write_en), .o_wb_sel(b_wb_sel), .o_br_type(b_br_type), .o_sel_A(b_sel_a),
      .o_sel_B(b_sel_b), .o_mdu_start(b_mdu_start), .o_mdu_op(b_mdu_op), .o_illegal(b_illegal),
      .o_illegal_cnt(b_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic br, input logic done);
      instr_valid = v;
      opcode      = op;
      funct3      = f3;
      funct7      = f7;
      br_taken    = br;
      mdu_done    = done;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {alu_op, reg_write, PCen, read_en, write_en, wb_sel, br_type, sel_A, sel_B, mdu_start, illegal}
   function automatic logic [16:0] ev(input logic [4:0] alu, input logic rw, input logic pc,
                                      input logic rd, input logic wr, input logic [1:0] wb,
                                      input logic [1:0] br, input logic sa, input logic sb,
                                      input logic st, input logic il);
      return {alu, rw, pc, rd, wr, wb, br, sa, sb, st, il};
   endfunction

   localparam logic [6:0] R   = 7'b0110011;
   localparam logic [6:0] MD  = 7'b0000001;
   localparam logic [6:0] BAD = 7'b1111111;

   initial begin
      logic [16:0] e_add, e_bub, e_ill, e_mstart, e_mwait, e_wb;
      int          exp_b_cnt [5];
      exp_b_cnt = '{1, 2, 3, 3, 3};
      e_add    = ev(5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
      e_bub    = ev(5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
      e_ill    = ev(5'd31, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
      e_mstart = ev(5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
      e_mwait  = ev(5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
      e_wb     = ev(5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);

      // Reset held with an ADD on the fields.
      rst_n = 1'b0;
      rst_n_b = 1'b0;
      drive(1'b1, R, 3'b000, 7'h00, 1'b0, 1'b0);
      tick();
      tick();
      chk("reset_vec_a", a_vec, 17'h0);
      chk("reset_cnt_a", a_cnt, 8'd0);
      chk("reset_mdu_op_a", a_mdu_op, 3'd0);
      chk("reset_vec_b", b_vec, 17'h0);

      rst_n = 1'b1;
      rst_n_b = 1'b1;
      tick();
      chk("first_add_a", a_vec, e_add);
      chk("first_add_b", b_vec, e_add);

      // Base decode sweep.
      drive(1'b1, R, 3'b000, 7'b0100000, 1'b0, 1'b0);
      tick();
      chk("sub", a_vec, ev(5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0));
      drive(1'b1, 7'b0010011, 3'b101, 7'b0100000, 1'b0, 1'b0);
      tick();
      chk("srai", a_vec, ev(5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0));
      drive(1'b1, 7'b0000011, 3'b010, 7'h00, 1'b0, 1'b0);
      tick();
      chk("lw", a_vec, ev(5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0));
      drive(1'b1, 7'b0100011, 3'b010, 7'h00, 1'b0, 1'b0);
      tick();
      chk("sw", a_vec, ev(5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0));
      drive(1'b1, 7'b1100011, 3'b000, 7'h00, 1'b0, 1'b0);
      tick();
      chk("beq", a_vec, ev(5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0));
      drive(1'b1, 7'b1100111, 3'b000, 7'h00, 1'b0, 1'b0);
      tick();
      chk("jalr", a_vec, ev(5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0));
      drive(1'b1, 7'b0110111, 3'b000, 7'h00, 1'b0, 1'b0);
      tick();
      chk("lui", a_vec, ev(5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0));

      drive(1'b0, R, 3'b000, 7'h00, 1'b0, 1'b0);
      tick();
      chk("invalid_bubble", a_vec, e_bub);

      // Load with reserved funct3 is illegal in both instances.
      drive(1'b1, 7'b0000011, 3'b011, 7'h00, 1'b0, 1'b0);
      tick();
      chk("ld011_ill_a", a_vec, e_ill);
      chk("ld011_cnt_a", a_cnt, 8'd1);
      chk("ld011_cnt_b", b_cnt, 2'd1);
      drive(1'b1, R, 3'b000, 7'h00, 1'b0, 1'b0);
      tick();
      chk("ill_pulse_end", a_vec, e_add);
      chk("ill_cnt_hold", a_cnt, 8'd1);

      // MUL: done raised three cycles after the start cycle.
      drive(1'b1, R, 3'b000, MD, 1'b0, 1'b0);
      tick();
      chk("mul_start", a_vec, e_mstart);
      chk("mul_op", a_mdu_op, 3'b000);
      chk("mul_nom_ill_b", b_vec, e_ill);
      chk("mul_nom_cnt_b", b_cnt, 2'd2);
      drive(1'b1, R, 3'b000, 7'h00, 1'b1, 1'b0);
      tick();
      chk("mul_wait1", a_vec, e_mwait);
      drive(1'b1, R, 3'b000, 7'h00, 1'b0, 1'b0);
      tick();
      chk("mul_wait2", a_vec, e_mwait);
      tick();
      chk("mul_wait3", a_vec, e_mwait);
      chk("wait_add_b", b_vec, e_add);
      mdu_done = 1'b1;
      tick();
      chk("mul_wb", a_vec, e_wb);
      mdu_done = 1'b0;
      tick();
      chk("post_mul_add", a_vec, e_add);

      // Flushes.
      drive(1'b1, R, 3'b000, 7'h00, 1'b1, 1'b0);
      tick();
      chk("flush_add", a_vec, e_bub);
      drive(1'b1, R, 3'b000, MD, 1'b1, 1'b0);
      tick();
      chk("flush_mop_a", a_vec, e_bub);
      chk("flush_mop_b", b_vec, e_bub);
      chk("flush_mop_cnt_b", b_cnt, 2'd2);
      drive(1'b1, BAD, 3'b000, 7'h00, 1'b1, 1'b0);
      tick();
      chk("flush_ill_a", a_vec, e_bub);
      chk("flush_ill_cnt_a", a_cnt, 8'd1);
      chk("flush_ill_cnt_b", b_cnt, 2'd2);

      // DIV with the earliest possible done.
      drive(1'b1, R, 3'b100, MD, 1'b0, 1'b0);
      tick();
      chk("div_start", a_vec, e_mstart);
      chk("div_op", a_mdu_op, 3'b100);
      chk("div_cnt_b", b_cnt, 2'd3);
      drive(1'b0, R, 3'b000, 7'h00, 1'b0, 1'b0);
      tick();
      chk("div_wait", a_vec, e_mwait);
      mdu_done = 1'b1;
      tick();
      chk("div_wb", a_vec, e_wb);
      chk("div_op_held", a_mdu_op, 3'b100);
      mdu_done = 1'b0;

      // Counter saturation on the 2-bit instance, starting from a fresh reset.
      rst_n_b = 1'b0;
      #1;
      chk("rst_b_cnt", b_cnt, 2'd0);
      rst_n_b = 1'b1;
      drive(1'b1, BAD, 3'b000, 7'h00, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("sat_cnt_b", b_cnt, exp_b_cnt[i]);
         chk("sat_ill_b", b_vec, e_ill);
         chk("sat_cnt_a", a_cnt, 32'(2 + i));
      end

      // Reset during MDU_WAIT; a later done must not produce a writeback.
      drive(1'b1, R, 3'b001, MD, 1'b0, 1'b0);
      tick();
      chk("mulh_start", a_vec, e_mstart);
      chk("mulh_op", a_mdu_op, 3'b001);
      drive(1'b0, R, 3'b000, 7'h00, 1'b0, 1'b0);
      tick();
      chk("mulh_wait", a_vec, e_mwait);
      #2;
      rst_n = 1'b0;
      rst_n_b = 1'b0;
      #1;
      chk("midrst_vec_a", a_vec, 17'h0);
      chk("midrst_cnt_a", a_cnt, 8'd0);
      chk("midrst_op_a", a_mdu_op, 3'd0);
      chk("midrst_cnt_b", b_cnt, 2'd0);
      mdu_done = 1'b1;
      #1;
      rst_n = 1'b1;
      rst_n_b = 1'b1;
      tick();
      chk("late_done_ignored", a_vec, e_bub);
      drive(1'b1, R, 3'b000, 7'h00, 1'b0, 1'b0);
      tick();
      chk("after_rst_add", a_vec, e_add);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
